// File: rtl/user_cmd_engine.sv
// user_cmd_engine: framed UART command parser driving byte-wide SDRAM requests.
// Optional macro USER_CMD_CHECKSUM_EN adds a running data checksum on R/W.
module user_cmd_engine #(
  parameter int unsigned ADDR_BITS      = 32,
  parameter int unsigned LEN_BITS       = 24,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [31:0] VERSION_STR    = "SPY2"
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           uart_rxd,
  input  logic                 uart_rxd_strobe,
  output logic [7:0]           uart_txd,
  output logic                 uart_txd_strobe,
  input  logic                 uart_txd_ready,
  output logic [ADDR_BITS-1:0] sd_addr,
  output logic [15:0]          sd_wr_data,
  output logic [1:0]           sd_wr_mask,
  input  logic [15:0]          sd_rd_data,
  input  logic                 sd_ack,
  input  logic                 sd_idle,
  output logic                 sd_we,
  output logic                 sd_enable,
  output logic                 busy
);
  localparam logic [3:0] S_WAIT    = 4'd0;
  localparam logic [3:0] S_CMD     = 4'd1;
  localparam logic [3:0] S_LEN     = 4'd2;
  localparam logic [3:0] S_ADDR    = 4'd3;
  localparam logic [3:0] S_RD_REQ  = 4'd4;
  localparam logic [3:0] S_RD_WAIT = 4'd5;
  localparam logic [3:0] S_WR_DATA = 4'd6;
  localparam logic [3:0] S_WR_WAIT = 4'd7;
  localparam logic [3:0] S_VER     = 4'd8;
`ifdef USER_CMD_CHECKSUM_EN
  localparam logic [3:0] S_CK_TX   = 4'd9;
  localparam logic [3:0] S_CK_RX   = 4'd10;
`endif

  localparam logic [2:0]  LB_LAST = 3'(LEN_BITS / 8 - 1);
  localparam logic [2:0]  AB_LAST = 3'(ADDR_BITS / 8 - 1);
  localparam bit          TO_EN   = TIMEOUT_CYCLES != 0;
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  logic [3:0]          state;
  logic [LEN_BITS-1:0] len;
  logic [2:0]          fcnt;
  logic [31:0]         tcnt;
  logic                is_wr;
  logic [7:0]          tx_byte;
  logic                tx_valid;
  logic                tx_fire;
  logic                tx_free;
  logic                timing;
  logic                to_hit;
  logic                len_last;
  logic [1:0]          vidx;
  logic [7:0]          rd_byte;
  logic [7:0]          ver_byte;
`ifdef USER_CMD_CHECKSUM_EN
  logic [7:0]          sum;
  assign timing = (state inside {S_CMD, S_LEN, S_ADDR, S_WR_DATA, S_CK_RX});
`else
  assign timing = (state inside {S_CMD, S_LEN, S_ADDR, S_WR_DATA});
`endif

  // A byte may be loaded on the same edge the previous one leaves.
  assign tx_fire  = tx_valid & uart_txd_ready & ~uart_txd_strobe;
  assign tx_free  = ~tx_valid | tx_fire;
  assign to_hit   = TO_EN && timing && !uart_rxd_strobe && tcnt == TO_LAST;
  assign len_last = len == LEN_BITS'(1);
  assign vidx     = len[1:0] - 2'd1;
  assign rd_byte  = sd_addr[0] ? sd_rd_data[15:8] : sd_rd_data[7:0];
  assign ver_byte = 8'(VERSION_STR >> {vidx, 3'b000});
  assign busy     = state != S_WAIT;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= S_WAIT;
      len             <= '0;
      fcnt            <= '0;
      tcnt            <= '0;
      is_wr           <= 1'b0;
      tx_byte         <= '0;
      tx_valid        <= 1'b0;
      uart_txd        <= '0;
      uart_txd_strobe <= 1'b0;
      sd_addr         <= '0;
      sd_wr_data      <= '0;
      sd_wr_mask      <= '0;
      sd_we           <= 1'b0;
      sd_enable       <= 1'b0;
`ifdef USER_CMD_CHECKSUM_EN
      sum             <= '0;
`endif
    end else begin
      uart_txd_strobe <= tx_fire;
      if (tx_fire) begin
        uart_txd <= tx_byte;
        tx_valid <= 1'b0;
      end
      // Saturates so a blocked timeout reply retries every cycle.
      if (uart_rxd_strobe || !timing) tcnt <= '0;
      else if (tcnt != TO_LAST) tcnt <= tcnt + 32'd1;

      if (to_hit) begin
        if (tx_free) begin
          tx_byte  <= "T";
          tx_valid <= 1'b1;
          state    <= S_WAIT;
        end
      end else begin
        unique case (state)
          S_WAIT: if (uart_rxd_strobe) begin
            if (uart_rxd == "!") begin
              state <= S_CMD;
`ifdef USER_CMD_CHECKSUM_EN
              sum   <= '0;
`endif
            end else if (tx_free) begin
              tx_byte  <= "!";
              tx_valid <= 1'b1;
            end
          end
          S_CMD: if (uart_rxd_strobe) begin
            fcnt <= '0;
            len  <= '0;
            if (uart_rxd == "R" || uart_rxd == "W") begin
              is_wr <= uart_rxd == "W";
              state <= S_LEN;
            end else if (uart_rxd == "V") begin
              len   <= LEN_BITS'(4);
              state <= S_VER;
            end else begin
              if (tx_free) begin
                tx_byte  <= "?";
                tx_valid <= 1'b1;
              end
              state <= S_WAIT;
            end
          end
          S_LEN: if (uart_rxd_strobe) begin
            len  <= (len << 8) | LEN_BITS'(uart_rxd);
            fcnt <= fcnt + 3'd1;
            if (fcnt == LB_LAST) begin
              fcnt  <= '0;
              state <= S_ADDR;
            end
          end
          S_ADDR: if (uart_rxd_strobe) begin
            sd_addr <= (sd_addr << 8) | ADDR_BITS'(uart_rxd);
            fcnt    <= fcnt + 3'd1;
            if (fcnt == AB_LAST) begin
              fcnt <= '0;
              if (len == '0) begin
                if (is_wr && tx_free) begin
                  tx_byte  <= "w";
                  tx_valid <= 1'b1;
                end
                state <= S_WAIT;
              end else begin
                state <= is_wr ? S_WR_DATA : S_RD_REQ;
              end
            end
          end
          S_RD_REQ: if (sd_idle && !sd_enable && !tx_valid) begin
            sd_enable <= 1'b1;
            sd_we     <= 1'b0;
            state     <= S_RD_WAIT;
          end
          S_RD_WAIT: if (sd_ack) begin
            sd_enable <= 1'b0;
            tx_byte   <= rd_byte;
            tx_valid  <= 1'b1;
            sd_addr   <= sd_addr + ADDR_BITS'(1);
            len       <= len - LEN_BITS'(1);
`ifdef USER_CMD_CHECKSUM_EN
            sum       <= sum + rd_byte;
            state     <= len_last ? S_CK_TX : S_RD_REQ;
`else
            state     <= len_last ? S_WAIT : S_RD_REQ;
`endif
          end
          S_WR_DATA: if (uart_rxd_strobe) begin
            sd_wr_data <= sd_addr[0] ? {uart_rxd, 8'h00} : {8'h00, uart_rxd};
            sd_wr_mask <= sd_addr[0] ? 2'b10 : 2'b01;
            sd_we      <= 1'b1;
            sd_enable  <= 1'b1;
            state      <= S_WR_WAIT;
`ifdef USER_CMD_CHECKSUM_EN
            sum        <= sum + uart_rxd;
`endif
          end
          S_WR_WAIT: if (uart_rxd_strobe) begin
            if (tx_free) begin
              tx_byte  <= "%";
              tx_valid <= 1'b1;
            end
            sd_enable <= 1'b0;
            sd_we     <= 1'b0;
            state     <= S_WAIT;
          end else if (sd_ack) begin
            sd_enable <= 1'b0;
            sd_we     <= 1'b0;
            sd_addr   <= sd_addr + ADDR_BITS'(1);
            len       <= len - LEN_BITS'(1);
            if (!len_last) state <= S_WR_DATA;
`ifdef USER_CMD_CHECKSUM_EN
            else state <= S_CK_RX;
`else
            else begin
              tx_byte  <= "w";
              tx_valid <= 1'b1;
              state    <= S_WAIT;
            end
`endif
          end
          S_VER: if (!tx_valid) begin
            tx_byte  <= ver_byte;
            tx_valid <= 1'b1;
            len      <= len - LEN_BITS'(1);
            if (len_last) state <= S_WAIT;
          end
`ifdef USER_CMD_CHECKSUM_EN
          S_CK_TX: if (!tx_valid) begin
            tx_byte  <= sum;
            tx_valid <= 1'b1;
            state    <= S_WAIT;
          end
          S_CK_RX: if (uart_rxd_strobe) begin
            if (tx_free) begin
              tx_byte  <= (uart_rxd == sum) ? "w" : "x";
              tx_valid <= 1'b1;
            end
            state <= S_WAIT;
          end
`endif
          default: state <= S_WAIT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_user_cmd_engine.sv
// tb_user_cmd_engine: scoreboard bench for user_cmd_engine.
// Expected tx bytes and SDRAM writes are queued at stimulus time.
`timescale 1ns/1ps
module tb_user_cmd_engine;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  uart_rxd;
  logic        uart_rxd_strobe;
  logic [7:0]  uart_txd;
  logic        uart_txd_strobe;
  logic        uart_txd_ready;
  logic [31:0] sd_addr;
  logic [15:0] sd_wr_data;
  logic [1:0]  sd_wr_mask;
  logic [15:0] sd_rd_data;
  logic        sd_ack;
  logic        sd_idle;
  logic        sd_we;
  logic        sd_enable;
  logic        busy;

  always #5 clk = ~clk;

  user_cmd_engine #(
    .ADDR_BITS(32),
    .LEN_BITS(24),
    .TIMEOUT_CYCLES(100),
    .VERSION_STR("SPY2")
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .uart_rxd(uart_rxd),
    .uart_rxd_strobe(uart_rxd_strobe),
    .uart_txd(uart_txd),
    .uart_txd_strobe(uart_txd_strobe),
    .uart_txd_ready(uart_txd_ready),
    .sd_addr(sd_addr),
    .sd_wr_data(sd_wr_data),
    .sd_wr_mask(sd_wr_mask),
    .sd_rd_data(sd_rd_data),
    .sd_ack(sd_ack),
    .sd_idle(sd_idle),
    .sd_we(sd_we),
    .sd_enable(sd_enable),
    .busy(busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [15:0] d;
    logic [1:0]  m;
  } wr_t;

  int          n_pass = 0;
  int          n_chk  = 0;
  int unsigned cyc    = 0;
  int unsigned ack_delay = 2;
  int unsigned dly_cnt   = 0;
  logic [7:0]  exp_q[$];
  wr_t         wr_q[$];
  logic [15:0] mem[int unsigned];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic logic [15:0] mem_rd(input logic [31:0] a);
    int unsigned w;
    w = a >> 1;
    return mem.exists(w) ? mem[w] : 16'h0000;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (uart_txd_strobe) begin
      if (exp_q.size() == 0) chk("tx_extra", {24'h0, uart_txd}, 32'h100);
      else chk("tx", {24'h0, uart_txd}, {24'h0, exp_q.pop_front()});
    end
  end

  // SDRAM model: acks after ack_delay cycles, applies masked writes.
  always @(negedge clk) begin
    if (sd_ack) begin
      sd_ack = 1'b0;
    end else if (sd_enable) begin
      if (dly_cnt >= ack_delay) begin
        dly_cnt = 0;
        sd_ack  = 1'b1;
        if (sd_we) begin
          logic [15:0] w;
          if (wr_q.size() == 0) begin
            chk("wr_extra", sd_addr, 32'hFFFF_FFFF);
          end else begin
            wr_t e;
            e = wr_q.pop_front();
            chk("wr_addr", sd_addr, e.a);
            chk("wr_data", {16'h0, sd_wr_data}, {16'h0, e.d});
            chk("wr_mask", {30'h0, sd_wr_mask}, {30'h0, e.m});
          end
          w = mem_rd(sd_addr);
          if (sd_wr_mask[0]) w[7:0] = sd_wr_data[7:0];
          if (sd_wr_mask[1]) w[15:8] = sd_wr_data[15:8];
          mem[sd_addr >> 1] = w;
        end else begin
          sd_rd_data = mem_rd(sd_addr);
        end
      end else begin
        dly_cnt++;
      end
    end else begin
      dly_cnt = 0;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    uart_rxd        = b;
    uart_rxd_strobe = 1'b1;
    @(negedge clk);
    uart_rxd_strobe = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] c, input logic [23:0] l,
                          input logic [31:0] a);
    send("!");
    send(c);
    for (int i = 2; i >= 0; i--) send(l[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) send(a[i*8 +: 8]);
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      if (sd_ack) break;
      n++;
    end
    chk("ack_seen", {31'h0, n < 100}, 32'h1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0 || wr_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'h0, n < budget}, 32'h1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0;
    int          n;
    reset_n         = 1'b0;
    uart_rxd        = '0;
    uart_rxd_strobe = 1'b0;
    uart_txd_ready  = 1'b1;
    sd_ack          = 1'b0;
    sd_idle         = 1'b1;
    sd_rd_data      = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_en", {31'h0, sd_enable}, 32'h0);
    chk("rst_we", {31'h0, sd_we}, 32'h0);
    chk("rst_txs", {31'h0, uart_txd_strobe}, 32'h0);
    chk("rst_txd", {24'h0, uart_txd}, 32'h0);
    chk("rst_addr", sd_addr, 32'h0);
    reset_n = 1'b1;

    // Version string, transmitter stalled first so the reply must be held.
    uart_txd_ready = 1'b0;
    exp_q.push_back("S");
    exp_q.push_back("P");
    exp_q.push_back("Y");
    exp_q.push_back("2");
    send("!");
    send("V");
    repeat (10) @(negedge clk);
    chk("ver_hold", exp_q.size(), 32'd4);
    chk("ver_busy", {31'h0, busy}, 32'h1);
    uart_txd_ready = 1'b1;
    wait_done("ver_done", 200);
    chk("ver_idle", {31'h0, busy}, 32'h0);

    // Read of 3 bytes starting at an odd address.
    mem[32'h08] = 16'hBBAA;
    mem[32'h09] = 16'hDDCC;
    exp_q.push_back(8'hBB);
    exp_q.push_back(8'hCC);
    exp_q.push_back(8'hDD);
`ifdef USER_CMD_CHECKSUM_EN
    exp_q.push_back(8'h64);
`endif
    send_hdr("R", 24'd3, 32'h11);
    wait_done("rd_done", 300);
    chk("rd_addr", sd_addr, 32'h14);

    // Write of 2 bytes, odd then even lane.
    wr_q.push_back('{a: 32'h5, d: 16'h5A00, m: 2'b10});
    wr_q.push_back('{a: 32'h6, d: 16'h006B, m: 2'b01});
    exp_q.push_back("w");
    send_hdr("W", 24'd2, 32'h5);
    send(8'h5A);
    wait_ack();
    send(8'h6B);
    wait_ack();
`ifdef USER_CMD_CHECKSUM_EN
    send(8'hC5);
`endif
    wait_done("wr_done", 300);
    chk("wr_mem2", {16'h0, mem_rd(32'h4)}, 32'h5A00);
    chk("wr_mem3", {16'h0, mem_rd(32'h6)}, 32'h006B);

    // Overrun: next data byte before the first ack.
    ack_delay = 20;
    exp_q.push_back("%");
    send_hdr("W", 24'd2, 32'h20);
    send(8'h11);
    send(8'h22);
    chk("ovr_en", {31'h0, sd_enable}, 32'h0);
    chk("ovr_busy", {31'h0, busy}, 32'h0);
    wait_done("ovr_done", 200);
    ack_delay = 2;
    repeat (30) @(negedge clk);
    chk("ovr_mem", {16'h0, mem_rd(32'h20)}, 32'h0);

    // Inter-byte timeout.
    exp_q.push_back("T");
    send("!");
    send("R");
    t0 = cyc;
    n  = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("to_lat", {31'h0, (cyc - t0 >= 99) && (cyc - t0 <= 103)}, 32'h1);
    chk("to_idle", {31'h0, busy}, 32'h0);

    // Bad command and stray byte.
    exp_q.push_back("?");
    send("!");
    send("Q");
    exp_q.push_back("!");
    send(8'h41);
    wait_done("err_done", 100);

    // Zero-length read is silent.
    send_hdr("R", 24'd0, 32'h40);
    repeat (10) @(negedge clk);
    chk("r0_busy", {31'h0, busy}, 32'h0);
    chk("r0_en", {31'h0, sd_enable}, 32'h0);

    // Two-byte read across the lanes of one word.
    mem[32'h18] = 16'hFF01;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hFF);
`ifdef USER_CMD_CHECKSUM_EN
    exp_q.push_back(8'h00);
`endif
    send_hdr("R", 24'd2, 32'h30);
    wait_done("rd2_done", 300);
    chk("rd2_addr", sd_addr, 32'h32);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
